// File: rtl/axi_master_pkg.sv
// rtl/axi_master_pkg.sv - shared constants, FSM state type and pattern helpers for the AXI burst master
package axi_master_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [3:0] AXCACHE_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Every 32-bit lane of beat g carries seed + g, wrapping mod 2^32.
  function automatic logic [31:0] pattern_word(input logic [31:0] seed, input logic [31:0] beat_idx);
    return seed + beat_idx;
  endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// rtl/axi_burst_master_if.sv - AXI4 full write/read channel bundle with master and slave views
interface axi_burst_master_if #(
  parameter int ID_W   = 2,
  parameter int ADDR_W = 41,
  parameter int DATA_W = 128
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_pattern_gen.sv
// rtl/axi_pattern_gen.sv - expected beat data for a global beat index and read-data compare
module axi_pattern_gen
  import axi_master_pkg::*;
#(
  parameter int          DATA_W       = 128,
  parameter logic [31:0] PATTERN_SEED = 32'hA5C3_0000
) (
  input  logic [31:0]       beat_idx,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] exp_data,
  output logic              rdata_match
);

  always_comb begin
    exp_data = '0;
    for (int i = 0; i < DATA_W / 32; i++) begin
      exp_data[i*32 +: 32] = pattern_word(PATTERN_SEED, beat_idx);
    end
  end

  assign rdata_match = (rdata == exp_data);

endmodule

// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - write-then-readback INCR burst traffic generator and checker
// Optional watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_burst_master
  import axi_master_pkg::*;
#(
  parameter int                            C_M_AXI_ID_WIDTH   = 2,
  parameter int                            C_M_AXI_ADDR_WIDTH = 41,
  parameter int                            C_M_AXI_DATA_WIDTH = 128,
  parameter int                            BURST_LEN          = 16,
  parameter int                            NUM_BURSTS         = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] TARGET_BASE_ADDR   = '0,
`ifdef AXI_MASTER_TIMEOUT_EN
  parameter int                            TIMEOUT_CYCLES     = 1024,
`endif
  parameter int                            TXN_ID             = 0,
  parameter logic [31:0]                   PATTERN_SEED       = 32'hA5C3_0000
) (
  input  logic                      M_AXI_ACLK,
  input  logic                      M_AXI_ARESETN,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [15:0]               error_count,
  output logic                      timeout,
  axi_burst_master_if.master        m_axi
);

  localparam int                            BURST_BYTES = BURST_LEN * (C_M_AXI_DATA_WIDTH / 8);
  localparam logic [2:0]                    AX_SIZE     = 3'(clog2(C_M_AXI_DATA_WIDTH / 8));
  localparam logic [C_M_AXI_ID_WIDTH-1:0]   ID          = C_M_AXI_ID_WIDTH'(TXN_ID);

  state_t                        state_q, state_d;
  logic [7:0]                    burst_q, burst_d, beat_q, beat_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                          busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [15:0]                   err_cnt_q, err_cnt_d;
  logic                          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                          arvalid_q, arvalid_d, rready_q, rready_d;
  logic [1:0]                    err_inc;
  logic                          last_beat, last_burst, rdata_match;
  logic [31:0]                   beat_idx;
  logic [C_M_AXI_DATA_WIDTH-1:0] exp_data;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + 17'(inc);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign last_beat  = (beat_q == 8'(BURST_LEN - 1));
  assign last_burst = (burst_q == 8'(NUM_BURSTS - 1));
  assign beat_idx   = 32'(burst_q) * 32'(BURST_LEN) + 32'(beat_q);

  axi_pattern_gen #(
    .DATA_W       (C_M_AXI_DATA_WIDTH),
    .PATTERN_SEED (PATTERN_SEED)
  ) u_pattern (
    .beat_idx    (beat_idx),
    .rdata       (m_axi.rdata),
    .exp_data    (exp_data),
    .rdata_match (rdata_match)
  );

`ifdef AXI_MASTER_TIMEOUT_EN
  logic        timeout_q, timeout_d;
  logic [31:0] wdog_q, wdog_d;
  logic        any_hs, wdog_fire;

  assign any_hs = (awvalid_q && m_axi.awready) || (wvalid_q && m_axi.wready) ||
                  (bready_q && m_axi.bvalid) || (arvalid_q && m_axi.arready) ||
                  (rready_q && m_axi.rvalid);
  assign wdog_fire = busy_q && !any_hs && (wdog_q == 32'(TIMEOUT_CYCLES - 1));
  assign timeout   = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    err_cnt_d = err_cnt_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    err_inc   = 2'd0;
`ifdef AXI_MASTER_TIMEOUT_EN
    timeout_d = timeout_q;
    wdog_d    = (any_hs || !busy_q) ? 32'd0 : wdog_q + 32'd1;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          burst_d   = '0;
          beat_d    = '0;
          addr_d    = TARGET_BASE_ADDR;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          error_d   = 1'b0;
          err_cnt_d = '0;
          awvalid_d = 1'b1;
          state_d   = ST_WR_ADDR;
`ifdef AXI_MASTER_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      ST_WR_ADDR: begin
        if (m_axi.awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          beat_d    = '0;
          state_d   = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (m_axi.wready) begin
          if (last_beat) begin
            wvalid_d = 1'b0;
            bready_d = 1'b1;
            beat_d   = '0;
            state_d  = ST_WR_RESP;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      ST_WR_RESP: begin
        if (m_axi.bvalid) begin
          if (m_axi.bresp != AXI_RESP_OKAY || m_axi.bid != ID) err_inc = 2'd1;
          bready_d  = 1'b0;
          arvalid_d = 1'b1;
          state_d   = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          beat_d    = '0;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (m_axi.rvalid) begin
          // Data/resp/id/early-last faults collapse to one error per beat; a missing last adds its own.
          err_inc = 2'({1'b0, (!rdata_match || m_axi.rresp != AXI_RESP_OKAY ||
                               m_axi.rid != ID || (m_axi.rlast && !last_beat))} +
                       {1'b0, (last_beat && !m_axi.rlast)});
          if (last_beat) begin
            rready_d = 1'b0;
            beat_d   = '0;
            if (last_burst) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              burst_d   = burst_q + 8'd1;
              addr_d    = addr_q + C_M_AXI_ADDR_WIDTH'(BURST_BYTES);
              awvalid_d = 1'b1;
              state_d   = ST_WR_ADDR;
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (err_inc != 2'd0) begin
      error_d   = 1'b1;
      err_cnt_d = sat_add(err_cnt_q, err_inc);
    end
`ifdef AXI_MASTER_TIMEOUT_EN
    if (wdog_fire) begin
      timeout_d = 1'b1;
      error_d   = 1'b1;
      err_cnt_d = sat_add(err_cnt_q, 2'd1);
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      beat_d    = '0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      state_d   = ST_DONE;
    end
`endif
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= ST_IDLE;
      burst_q   <= '0;
      beat_q    <= '0;
      addr_q    <= TARGET_BASE_ADDR;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
      timeout_q <= 1'b0;
      wdog_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
`ifdef AXI_MASTER_TIMEOUT_EN
      timeout_q <= timeout_d;
      wdog_q    <= wdog_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign error_count = err_cnt_q;

  assign m_axi.awid    = ID;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = 8'(BURST_LEN - 1);
  assign m_axi.awsize  = AX_SIZE;
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = AXCACHE_DEFAULT;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awqos   = 4'b0000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = exp_data;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = wvalid_q && last_beat;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.arid    = ID;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = 8'(BURST_LEN - 1);
  assign m_axi.arsize  = AX_SIZE;
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = AXCACHE_DEFAULT;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arqos   = 4'b0000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule
